// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction cache controller.
//   - geometry constants (2-way, 64 sets, 4 x 32-bit words per line)
//   - controller state encoding
//   - core address field split helpers
// ---------------------------------------------------------------------------
package icache_pkg;

  localparam int SET_W      = 6;
  localparam int TAG_W      = 22;
  localparam int LINE_WORDS = 4;
  localparam int WORD_SEL_W = 2;
  localparam int NUM_SETS   = 1 << SET_W;
  localparam int LINE_W     = 32 * LINE_WORDS;
  localparam int FLUSH_W    = SET_W + 1;   // walks {set, way}

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    LOOK0,
    LOOK1,
    REFILL,
    WRITE
  } state_t;

  // Word-granular view of a core byte address: {tag, set, word}.
  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [SET_W-1:0]      set;
    logic [WORD_SEL_W-1:0] word;
  } line_addr_t;

  // Drops the byte offset and splits the rest into cache fields.
  function automatic line_addr_t split_addr(input logic [31:0] byte_addr);
    return line_addr_t'(byte_addr >> 2);
  endfunction

  // Byte address of one word of a line.
  function automatic logic [31:0] word_addr(input logic [TAG_W-1:0]      tag,
                                            input logic [SET_W-1:0]      set,
                                            input logic [WORD_SEL_W-1:0] word);
    return {tag, set, word, 2'b00};
  endfunction

endpackage

// File: rtl/icache_lru.sv
// ---------------------------------------------------------------------------
// icache_lru
// One LRU bit per set. The bit names the way to evict next.
// Ports:
//   clk, reset        clock, asynchronous active-high reset (clears all bits)
//   rd_set / rd_bit   combinational read port
//   wr_en / wr_set /
//   wr_bit            synchronous write port
// ---------------------------------------------------------------------------
module icache_lru
  import icache_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [SET_W-1:0] rd_set,
  output logic             rd_bit,
  input  logic             wr_en,
  input  logic [SET_W-1:0] wr_set,
  input  logic             wr_bit
);

  logic lru_reg [NUM_SETS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        lru_reg[i] <= 1'b0;
      end
    end else if (wr_en) begin
      lru_reg[wr_set] <= wr_bit;
    end
  end

  assign rd_bit = lru_reg[rd_set];

endmodule

// File: rtl/icache_ctrl.sv
// ---------------------------------------------------------------------------
// icache_ctrl
// Read-only 2-way instruction cache controller in front of cache_mem_wrap.
// Looks up way 0 then way 1 through the single set/way port, refills misses
// from the memory bus as four word reads, and supports bulk invalidation.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   core_req_i/core_addr_i/
//   core_gnt_o/core_rvalid_o/
//   core_rdata_o                     core fetch port (one request in flight)
//   flush_i/flush_busy_o             invalidate-all request / busy status
//   mem_req_o/mem_addr_o/mem_gnt_i/
//   mem_rvalid_i/mem_rdata_i         memory word-read bus (in-order responses)
//   set/way/enable/write_enable/
//   val_write_enable/line_valid_i/
//   line_tag_i/line_i/line_be_i      cache_mem_wrap command/write side
//   line_valid_o/line_tag_o/line_o   cache_mem_wrap read side (1-cycle latency)
// ---------------------------------------------------------------------------
module icache_ctrl
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req_i,
  input  logic [31:0]       core_addr_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [31:0]       core_rdata_o,
  input  logic              flush_i,
  output logic              flush_busy_o,
  output logic              mem_req_o,
  output logic [31:0]       mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [SET_W-1:0]  set,
  output logic              way,
  output logic              enable,
  output logic              write_enable,
  output logic              val_write_enable,
  output logic              line_valid_i,
  output logic [TAG_W-1:0]  line_tag_i,
  output logic [LINE_W-1:0] line_i,
  output logic [15:0]       line_be_i,
  input  logic              line_valid_o,
  input  logic [TAG_W-1:0]  line_tag_o,
  input  logic [LINE_W-1:0] line_o
);

  state_t               state;
  line_addr_t           addr_reg;
  logic [FLUSH_W-1:0]   flush_cnt;
  logic [2:0]           issue_cnt;   // 0..4, stops requesting at 4
  logic [1:0]           rcv_cnt;
  logic                 victim_reg;
  logic [31:0]          line_buf [LINE_WORDS];
  logic [31:0]          rd_words [LINE_WORDS];

  line_addr_t           req_fields;
  logic                 grant;
  logic                 tag_hit;
  logic                 lru_rd;
  logic                 lru_we;
  logic                 lru_wbit;

  assign req_fields = split_addr(core_addr_i);

  // Flush wins over a simultaneous core request.
  assign grant        = (state == IDLE) && !flush_i && core_req_i;
  assign core_gnt_o   = grant;
  assign flush_busy_o = (state == FLUSH);

  assign mem_req_o  = (state == REFILL) && !issue_cnt[2];
  assign mem_addr_o = word_addr(addr_reg.tag, addr_reg.set, issue_cnt[1:0]);

  // The read side always reflects whichever way was addressed last cycle,
  // so the same compare serves LOOK0 (way 0) and LOOK1 (way 1).
  assign tag_hit = line_valid_o && (line_tag_o == addr_reg.tag);

  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_words
    assign rd_words[gi]          = line_o[32*gi +: 32];
    assign line_i[32*gi +: 32]   = line_buf[gi];
  end

  assign line_tag_i = addr_reg.tag;
  assign line_be_i  = 16'hFFFF;

  // Cache memory command port.
  always_comb begin
    enable           = 1'b0;
    write_enable     = 1'b0;
    val_write_enable = 1'b0;
    line_valid_i     = 1'b0;
    set              = addr_reg.set;
    way              = 1'b0;
    case (state)
      FLUSH: begin
        enable           = 1'b1;
        val_write_enable = 1'b1;
        set              = flush_cnt[FLUSH_W-1:1];
        way              = flush_cnt[0];
      end
      IDLE: begin
        if (grant) begin
          enable = 1'b1;
          set    = req_fields.set;
        end
      end
      LOOK0: begin
        // Way 0 result arrives while way 1 is being read.
        enable = 1'b1;
        way    = 1'b1;
      end
      WRITE: begin
        enable           = 1'b1;
        write_enable     = 1'b1;
        val_write_enable = 1'b1;
        line_valid_i     = 1'b1;
        way              = victim_reg;
      end
      default: ;
    endcase
  end

  // LRU bit points at the way not most recently used.
  always_comb begin
    lru_we   = 1'b0;
    lru_wbit = 1'b0;
    case (state)
      LOOK0: begin
        lru_we   = tag_hit;
        lru_wbit = 1'b1;
      end
      LOOK1: begin
        lru_we   = tag_hit;
        lru_wbit = 1'b0;
      end
      WRITE: begin
        lru_we   = 1'b1;
        lru_wbit = ~victim_reg;
      end
      default: ;
    endcase
  end

  icache_lru u_lru (
    .clk    (clk),
    .reset  (reset),
    .rd_set (addr_reg.set),
    .rd_bit (lru_rd),
    .wr_en  (lru_we),
    .wr_set (addr_reg.set),
    .wr_bit (lru_wbit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FLUSH;
      flush_cnt     <= '0;
      addr_reg      <= '0;
      issue_cnt     <= '0;
      rcv_cnt       <= '0;
      victim_reg    <= 1'b0;
      core_rvalid_o <= 1'b0;
      core_rdata_o  <= '0;
    end else begin
      core_rvalid_o <= 1'b0;
      case (state)
        FLUSH: begin
          // Counter wraps back to 0, ready for the next flush.
          flush_cnt <= flush_cnt + 1'b1;
          if (&flush_cnt) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (flush_i) begin
            state <= FLUSH;
          end else if (core_req_i) begin
            addr_reg <= req_fields;
            state    <= LOOK0;
          end
        end
        LOOK0: begin
          if (tag_hit) begin
            core_rdata_o  <= rd_words[addr_reg.word];
            core_rvalid_o <= 1'b1;
            state         <= IDLE;
          end else begin
            state <= LOOK1;
          end
        end
        LOOK1: begin
          if (tag_hit) begin
            core_rdata_o  <= rd_words[addr_reg.word];
            core_rvalid_o <= 1'b1;
            state         <= IDLE;
          end else begin
            victim_reg <= lru_rd;
            issue_cnt  <= '0;
            rcv_cnt    <= '0;
            state      <= REFILL;
          end
        end
        REFILL: begin
          if (mem_req_o && mem_gnt_i) begin
            issue_cnt <= issue_cnt + 1'b1;
          end
          if (mem_rvalid_i) begin
            rcv_cnt <= rcv_cnt + 1'b1;
            if (rcv_cnt == 2'd3) begin
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          core_rdata_o  <= line_buf[addr_reg.word];
          core_rvalid_o <= 1'b1;
          state         <= IDLE;
        end
        default: state <= FLUSH;
      endcase
    end
  end

  // Refill assembly buffer; pure datapath, no reset needed.
  always_ff @(posedge clk) begin
    if ((state == REFILL) && mem_rvalid_i) begin
      line_buf[rcv_cnt] <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;
  import icache_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              core_req_i = 1'b0;
  logic [31:0]       core_addr_i = '0;
  logic              core_gnt_o;
  logic              core_rvalid_o;
  logic [31:0]       core_rdata_o;
  logic              flush_i = 1'b0;
  logic              flush_busy_o;
  logic              mem_req_o;
  logic [31:0]       mem_addr_o;
  logic              mem_gnt_i = 1'b0;
  logic              mem_rvalid_i = 1'b0;
  logic [31:0]       mem_rdata_i = '0;
  logic [SET_W-1:0]  set;
  logic              way;
  logic              enable;
  logic              write_enable;
  logic              val_write_enable;
  logic              line_valid_i;
  logic [TAG_W-1:0]  line_tag_i;
  logic [LINE_W-1:0] line_i;
  logic [15:0]       line_be_i;
  logic              line_valid_o = 1'b0;
  logic [TAG_W-1:0]  line_tag_o = '0;
  logic [LINE_W-1:0] line_o = '0;

  always #5 clk = ~clk;

  icache_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .core_req_i       (core_req_i),
    .core_addr_i      (core_addr_i),
    .core_gnt_o       (core_gnt_o),
    .core_rvalid_o    (core_rvalid_o),
    .core_rdata_o     (core_rdata_o),
    .flush_i          (flush_i),
    .flush_busy_o     (flush_busy_o),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_gnt_i        (mem_gnt_i),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rdata_i      (mem_rdata_i),
    .set              (set),
    .way              (way),
    .enable           (enable),
    .write_enable     (write_enable),
    .val_write_enable (val_write_enable),
    .line_valid_i     (line_valid_i),
    .line_tag_i       (line_tag_i),
    .line_i           (line_i),
    .line_be_i        (line_be_i),
    .line_valid_o     (line_valid_o),
    .line_tag_o       (line_tag_o),
    .line_o           (line_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not as expected", name);
  endfunction

  // Backing memory contents: fixed pattern for the 0x1230 line, hash elsewhere.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a[31:4] == 28'h000_0123) return 32'hA0 + {28'h0, a[3:2]};
    return (a * 32'd2654435761) ^ 32'h5A5A_5A5A;
  endfunction

  // ---------------- cache_mem_wrap behavioural model ----------------
  logic              cm_valid [2][64];
  logic [TAG_W-1:0]  cm_tag   [2][64];
  logic [LINE_W-1:0] cm_line  [2][64];
  bit                cm_init = 1'b0;

  always @(posedge clk) begin
    if (!cm_init) begin
      // Pre-fill with valid garbage so a missing flush shows up as false hits.
      for (int w = 0; w < 2; w++) begin
        for (int s = 0; s < 64; s++) begin
          cm_valid[w][s] <= 1'b1;
          cm_tag[w][s]   <= '1;
          cm_line[w][s]  <= '1;
        end
      end
      cm_init <= 1'b1;
    end else if (enable) begin
      line_valid_o <= cm_valid[way][set];
      line_tag_o   <= cm_tag[way][set];
      line_o       <= cm_line[way][set];
      if (val_write_enable) cm_valid[way][set] <= line_valid_i;
      if (write_enable) begin
        cm_tag[way][set]  <= line_tag_i;
        cm_line[way][set] <= line_i;
      end
    end
  end

  // ---------------- reference model (cache directory) ----------------
  bit               ref_valid [2][64];
  logic [TAG_W-1:0] ref_tag   [2][64];
  bit               ref_lru   [64];

  typedef struct {
    logic [31:0] data;
    int          lat;   // 0 = miss (only lower-bounded)
  } exp_t;

  typedef struct {
    logic              way;
    logic [5:0]        set;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] line;
  } wr_exp_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } pend_t;

  exp_t        sb_q[$];
  wr_exp_t     wr_q[$];
  logic [31:0] mem_exp_q[$];
  pend_t       pend_q[$];
  int          grant_cyc = 0;

  task automatic model_flush();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 64; s++) ref_valid[w][s] = 1'b0;
  endtask

  task automatic model_reset();
    model_flush();
    for (int s = 0; s < 64; s++) ref_lru[s] = 1'b0;
  endtask

  task automatic model_predict(input logic [31:0] addr);
    exp_t        e;
    wr_exp_t     we;
    logic [5:0]  s;
    logic [21:0] t;
    logic        v;
    s = addr[9:4];
    t = addr[31:10];
    e.data = mem_data({addr[31:2], 2'b00});
    if (ref_valid[0][s] && ref_tag[0][s] == t) begin
      e.lat = 2;
      ref_lru[s] = 1'b1;
    end else if (ref_valid[1][s] && ref_tag[1][s] == t) begin
      e.lat = 3;
      ref_lru[s] = 1'b0;
    end else begin
      e.lat = 0;
      v = ref_lru[s];
      we.way = v;
      we.set = s;
      we.tag = t;
      for (int w = 0; w < 4; w++) begin
        mem_exp_q.push_back({t, s, 2'(w), 2'b00});
        we.line[32*w +: 32] = mem_data({t, s, 2'(w), 2'b00});
      end
      wr_q.push_back(we);
      ref_valid[v][s] = 1'b1;
      ref_tag[v][s]   = t;
      ref_lru[s]      = ~v;
    end
    sb_q.push_back(e);
  endtask

  task automatic clear_queues();
    sb_q.delete();
    wr_q.delete();
    mem_exp_q.delete();
  endtask

  // ---------------- memory bus responder ----------------
  bit rand_mode = 1'b0;
  int fix_stall = 0;
  int fix_rv    = 1;
  int wait_cnt  = 0;
  int cur_stall = 0;
  int cur_rv    = 1;
  int last_due  = 0;

  task automatic set_mem(input bit rnd, input int stall, input int rv);
    rand_mode = rnd;
    fix_stall = stall;
    fix_rv    = rv;
    cur_stall = rnd ? int'($urandom_range(0, 2)) : stall;
    cur_rv    = rnd ? int'($urandom_range(1, 4)) : rv;
  endtask

  always @(negedge clk) begin
    pend_t p;
    if (reset) begin
      pend_q.delete();
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      wait_cnt     = 0;
      last_due     = 0;
    end else begin
      mem_rvalid_i = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        p = pend_q.pop_front();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = p.data;
      end
      mem_gnt_i = 1'b0;
      if (mem_req_o) begin
        if (wait_cnt >= cur_stall) begin
          mem_gnt_i = 1'b1;
          if (mem_exp_q.size() == 0) fail_now("unexpected_mem_req");
          else check("mem_addr", mem_addr_o, mem_exp_q.pop_front());
          p.data = mem_data(mem_addr_o);
          p.due  = (cyc + cur_rv > last_due + 1) ? cyc + cur_rv : last_due + 1;
          last_due = p.due;
          pend_q.push_back(p);
          wait_cnt  = 0;
          cur_stall = rand_mode ? int'($urandom_range(0, 2)) : fix_stall;
          cur_rv    = rand_mode ? int'($urandom_range(1, 4)) : fix_rv;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && core_rvalid_o === 1'b1) begin
      if (sb_q.size() == 0) fail_now("unexpected_rvalid");
      else begin
        e = sb_q.pop_front();
        check("rdata", core_rdata_o, e.data);
        if (e.lat != 0) check("hit_latency", cyc - grant_cyc, e.lat);
        else check("miss_latency_gt3", (cyc - grant_cyc) > 3, 1'b1);
        $display("txn: rdata=%08h lat=%0d", core_rdata_o, cyc - grant_cyc);
      end
    end
  end

  always @(negedge clk) begin
    wr_exp_t w;
    if (reset === 1'b0 && enable === 1'b1 && write_enable === 1'b1) begin
      if (wr_q.size() == 0) fail_now("unexpected_line_write");
      else begin
        w = wr_q.pop_front();
        check("wr_way", way, w.way);
        check("wr_set", set, w.set);
        check("wr_tag", line_tag_i, w.tag);
        check("wr_line", line_i, w.line);
        check("wr_valid", {val_write_enable, line_valid_i, line_be_i}, {2'b11, 16'hFFFF});
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic issue(input logic [31:0] addr, output int tries);
    bit granted;
    granted = 1'b0;
    tries   = 0;
    model_predict(addr);
    while (!granted && tries < 300) begin
      @(negedge clk);
      core_req_i  = 1'b1;
      core_addr_i = addr;
      #1;
      tries++;
      if (core_gnt_o) begin
        granted   = 1'b1;
        grant_cyc = cyc;
      end
    end
    if (!granted) begin
      fail_now("grant_timeout");
      core_req_i = 1'b0;
      clear_queues();
    end else begin
      @(negedge clk);
      core_req_i = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 400) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (sb_q.size() != 0) begin
      fail_now("rvalid_timeout");
      clear_queues();
    end else begin
      check("mem_reqs_outstanding", mem_exp_q.size(), 0);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, output int tries);
    issue(addr, tries);
    wait_done();
  endtask

  // Called at a sample point with the flush already underway.
  task automatic count_flush();
    int busy, vw, walk_err;
    busy = 0; vw = 0; walk_err = 0;
    for (int i = 0; i < 300; i++) begin
      if (!flush_busy_o) break;
      if (enable && val_write_enable && !write_enable && !line_valid_i) vw++;
      if ({set, way} != 7'(busy)) walk_err++;
      busy++;
      @(negedge clk);
      #1;
    end
    check("flush_cycles", busy, 128);
    check("flush_valid_writes", vw, 128);
    check("flush_walk_errors", walk_err, 0);
    $display("txn: flush busy=%0d cycles", busy);
  endtask

  task automatic flush_with_req(input logic [31:0] addr);
    @(negedge clk);
    flush_i     = 1'b1;
    core_req_i  = 1'b1;
    core_addr_i = addr;
    #1;
    check("gnt_blocked_by_flush", core_gnt_o, 1'b0);
    @(negedge clk);
    flush_i    = 1'b0;
    core_req_i = 1'b0;
    #1;
    count_flush();
    model_flush();
  endtask

  task automatic check_reset_outputs();
    check("rst_gnt", core_gnt_o, 1'b0);
    check("rst_rvalid", core_rvalid_o, 1'b0);
    check("rst_rdata", core_rdata_o, 32'h0);
    check("rst_mem_req", mem_req_o, 1'b0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_write_enable", write_enable, 1'b0);
    check("rst_flush_busy", flush_busy_o, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          tries;
    int          t;
    logic [31:0] a;
    logic [21:0] tg;
    logic [5:0]  st;

    set_mem(1'b0, 0, 1);
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    #1;
    count_flush();

    // Idle: grant follows request.
    check("idle_gnt_no_req", core_gnt_o, 1'b0);
    do_read(32'h0000_1234, tries);
    check("first_grant_immediate", tries, 1);
    do_read(32'h0000_1238, tries);
    do_read(32'h0000_5230, tries);
    do_read(32'h0000_5230, tries);
    do_read(32'h0000_9230, tries);
    do_read(32'h0000_1234, tries);

    // Slow memory: grant stalls and long response delay.
    set_mem(1'b0, 3, 5);
    do_read(32'h0000_7348, tries);
    do_read(32'h0000_734C, tries);

    // Flush and request together.
    set_mem(1'b0, 0, 1);
    flush_with_req(32'h0000_9230);
    do_read(32'h0000_9230, tries);

    // Randomized traffic over two sets and a handful of tags.
    set_mem(1'b1, 0, 1);
    for (int i = 0; i < 60; i++) begin
      tg = 22'($urandom_range(0, 3)) + 22'h10;
      st = ($urandom_range(0, 1) == 1) ? 6'h23 : 6'h05;
      a  = {tg, st, 2'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 14) == 0) flush_with_req(a);
      else do_read(a, tries);
    end

    // Reset in the middle of a refill.
    set_mem(1'b0, 3, 5);
    issue(32'h0000_B670, tries);
    t = 0;
    while (!mem_req_o && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("refill_reached", mem_req_o, 1'b1);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    clear_queues();
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    count_flush();
    do_read(32'h0000_B670, tries);
    do_read(32'h0000_B674, tries);

    repeat (5) @(negedge clk);
    check("sb_empty_at_end", sb_q.size() + wr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
